// File: rtl/miner_job_controller_pkg.sv
// Shared constants and types for the miner job controller.
// Status codes, frame layout and FSM states.
package miner_job_controller_pkg;

    localparam logic [7:0] ST_EXHAUSTED = 8'h00;
    localparam logic [7:0] ST_FOUND     = 8'h01;
    localparam logic [7:0] ST_ABORTED   = 8'h02;
    localparam logic [7:0] ST_REJECTED  = 8'h03;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned FRAME_LEN    = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_e;

endpackage

// File: rtl/miner_job_controller_tx.sv
// Result frame serializer: SYNC, id, status, nonce MSB..LSB.
// Streams the frame over a valid/ready byte interface.
module result_frame_tx
    import miner_job_controller_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic        hash_clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [7:0]  id,
    input  logic [7:0]  status,
    input  logic [31:0] nonce,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        done
);

    logic [2:0]  idx_q;
    logic [7:0]  id_q;
    logic [7:0]  status_q;
    logic [31:0] nonce_q;
    logic [7:0]  byte_sel;

    assign done = tx_valid && tx_ready && (idx_q == 3'(FRAME_LEN - 1));

    always_comb begin
        byte_sel = 8'h00;
        unique case (idx_q)
            3'd0:    byte_sel = SYNC_BYTE;
            3'd1:    byte_sel = id_q;
            3'd2:    byte_sel = status_q;
            3'd3:    byte_sel = nonce_q[31:24];
            3'd4:    byte_sel = nonce_q[23:16];
            3'd5:    byte_sel = nonce_q[15:8];
            3'd6:    byte_sel = nonce_q[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    // Keep the bus quiet whenever no byte is being offered.
    assign tx_data = tx_valid ? byte_sel : 8'h00;

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= '0;
            id_q     <= '0;
            status_q <= '0;
            nonce_q  <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            idx_q    <= '0;
            id_q     <= id;
            status_q <= status;
            nonce_q  <= nonce;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (done) begin
                idx_q    <= '0;
                tx_valid <= 1'b0;
            end else begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/miner_job_controller.sv
// Host-side job controller for the hashing core.
// Launches one job, waits for result/abort/exhaustion, reports a frame.
module miner_job_controller
    import miner_job_controller_pkg::*;
#(
    parameter int unsigned LOOP_LOG2    = 5,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 160,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic         hash_clk,
    input  logic         reset_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [7:0]   job_id,
    input  logic [255:0] job_midstate,
    input  logic [95:0]  job_data,
    input  logic [31:0]  job_nonce_min,
    input  logic [31:0]  job_nonce_max,
    input  logic         abort,
    output logic [255:0] midstate,
    output logic [95:0]  work_data,
    output logic [31:0]  nonce_min,
    output logic [31:0]  nonce_max,
    output logic         miner_reset,
    input  logic [31:0]  golden_nonce,
    input  logic         new_golden_nonce,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         busy
);

    localparam int unsigned CW = 33 + LOOP_LOG2;
    localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] budget_q;
    logic [CW-1:0] budget_init;
    logic [SW-1:0] start_cnt_q;
    logic [7:0]    id_q;
    logic          accept;
    logic          load;
    logic [7:0]    ld_id;
    logic [7:0]    ld_status;
    logic [31:0]   ld_nonce;
    logic          frame_done;
    logic          range_ok;

    assign accept   = job_valid && job_ready;
    assign range_ok = job_nonce_max >= job_nonce_min;
    assign busy     = state_q != S_IDLE;

    // Every nonce costs 2^LOOP_LOG2 cycles, plus a pipeline flush margin.
    assign budget_init =
        ((CW'(job_nonce_max) - CW'(job_nonce_min) + CW'(1)) << LOOP_LOG2)
        + CW'(DRAIN_CYCLES);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        ld_id     = id_q;
        ld_status = ST_EXHAUSTED;
        ld_nonce  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!range_ok) begin
                        state_d   = S_REPORT;
                        load      = 1'b1;
                        ld_id     = job_id;
                        ld_status = ST_REJECTED;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (start_cnt_q == '0) state_d = S_RUN;
            end
            S_RUN: begin
                if (new_golden_nonce) begin
                    load      = 1'b1;
                    ld_status = ST_FOUND;
                    ld_nonce  = golden_nonce;
                end else if (abort) begin
                    load      = 1'b1;
                    ld_status = ST_ABORTED;
                end else if (budget_q <= CW'(1)) begin
                    load      = 1'b1;
                    ld_status = ST_EXHAUSTED;
                    ld_nonce  = nonce_max;
                end
                if (load) state_d = S_REPORT;
            end
            S_REPORT: begin
                if (frame_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            job_ready   <= 1'b0;
            budget_q    <= '0;
            start_cnt_q <= '0;
            id_q        <= '0;
            midstate    <= '0;
            work_data   <= '0;
            nonce_min   <= '0;
            nonce_max   <= '0;
            miner_reset <= 1'b0;
        end else begin
            state_q   <= state_d;
            job_ready <= state_d == S_IDLE;
            if (accept) begin
                id_q        <= job_id;
                midstate    <= job_midstate;
                work_data   <= job_data;
                nonce_min   <= job_nonce_min;
                nonce_max   <= job_nonce_max;
                budget_q    <= budget_init;
                start_cnt_q <= SW'(START_CYCLES - 1);
                miner_reset <= range_ok;
            end
            if (state_q == S_START) begin
                if (start_cnt_q == '0) miner_reset <= 1'b0;
                else start_cnt_q <= start_cnt_q - SW'(1);
            end
            if (state_q == S_RUN) budget_q <= budget_q - CW'(1);
        end
    end

    result_frame_tx #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_tx (
        .hash_clk (hash_clk),
        .reset_n  (reset_n),
        .load     (load),
        .id       (ld_id),
        .status   (ld_status),
        .nonce    (ld_nonce),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .done     (frame_done)
    );

endmodule

// File: tb/tb_miner_job_controller.sv
// Scoreboard bench for miner_job_controller.
// Expected frames are queued by stimulus; a monitor checks the byte stream.
module tb_miner_job_controller;

    logic         hash_clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [7:0]   job_id = '0;
    logic [255:0] job_midstate = '0;
    logic [95:0]  job_data = '0;
    logic [31:0]  job_nonce_min = '0;
    logic [31:0]  job_nonce_max = '0;
    logic         abort = 1'b0;
    logic [255:0] midstate;
    logic [95:0]  work_data;
    logic [31:0]  nonce_min;
    logic [31:0]  nonce_max;
    logic         miner_reset;
    logic [31:0]  golden_nonce = '0;
    logic         new_golden_nonce = 1'b0;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   tx_data;
    logic         busy;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  stall_cnt = 0;
    bit  rand_rdy = 1'b0;
    int  mon_idx = 0;
    logic [7:0] exp_q[$];

    miner_job_controller dut (
        .hash_clk         (hash_clk),
        .reset_n          (reset_n),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_id           (job_id),
        .job_midstate     (job_midstate),
        .job_data         (job_data),
        .job_nonce_min    (job_nonce_min),
        .job_nonce_max    (job_nonce_max),
        .abort            (abort),
        .midstate         (midstate),
        .work_data        (work_data),
        .nonce_min        (nonce_min),
        .nonce_max        (nonce_max),
        .miner_reset      (miner_reset),
        .golden_nonce     (golden_nonce),
        .new_golden_nonce (new_golden_nonce),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .busy             (busy)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] id, input logic [7:0] st,
                              input logic [31:0] nonce);
        exp_q.push_back(8'hA5);
        exp_q.push_back(id);
        exp_q.push_back(st);
        for (int i = 3; i >= 0; i--) exp_q.push_back(nonce[i*8 +: 8]);
    endtask

    // tx_ready driver: always-ready, random, or a forced stall window.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge hash_clk);
            #1;
            if (stall_cnt > 0) begin
                tx_ready = 1'b0;
                stall_cnt--;
            end else begin
                tx_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    // Monitor: pops expected bytes on each handshake, checks stall stability.
    initial begin
        bit         prev_stall = 0;
        bit         chk_idle = 0;
        logic [7:0] prev_data = '0;
        logic [7:0] e;
        forever begin
            @(negedge hash_clk);
            if (!reset_n) begin
                prev_stall = 0;
                chk_idle = 0;
                mon_idx = 0;
                continue;
            end
            if (chk_idle) begin
                check("idle_after_frame",
                      64'({job_ready, busy, tx_valid}), 64'(3'b100));
                chk_idle = 0;
            end
            if (prev_stall) begin
                check("stall_valid", 64'(tx_valid), 64'(1));
                check("stall_data", 64'(tx_data), 64'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 64'(tx_data), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("frame_byte%0d", mon_idx),
                          64'(tx_data), 64'(e));
                end
                mon_idx++;
                if (mon_idx == 7) begin
                    mon_idx = 0;
                    chk_idle = 1;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_zero(input string nm);
        check(nm, 64'(midstate != '0 || work_data != '0), 64'(0));
        check({nm, "_ctl"},
              64'({job_ready, nonce_min, nonce_max, miner_reset,
                   tx_valid, tx_data, busy}), 64'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20000) begin
            @(posedge hash_clk);
            #1;
            n++;
        end
        check("idle_timeout", 64'(n >= 20000), 64'(0));
    endtask

    task automatic send_job(input logic [7:0] id, input logic [31:0] mn,
                            input logic [31:0] mx);
        logic [255:0] ms;
        logic [95:0]  wd;
        int n = 0;
        for (int i = 0; i < 8; i++) ms[i*32 +: 32] = $urandom;
        for (int i = 0; i < 3; i++) wd[i*32 +: 32] = $urandom;
        while (!job_ready && n < 1000) begin
            @(posedge hash_clk);
            #1;
            n++;
        end
        check("job_ready_timeout", 64'(n >= 1000), 64'(0));
        job_valid = 1'b1;
        job_id = id;
        job_midstate = ms;
        job_data = wd;
        job_nonce_min = mn;
        job_nonce_max = mx;
        @(posedge hash_clk);
        #1;
        job_valid = 1'b0;
        job_midstate = '0;
        job_data = '0;
        check("core_midstate", 64'(midstate == ms), 64'(1));
        check("core_work_data", 64'(work_data == wd), 64'(1));
        check("core_nonce_range", {nonce_min, nonce_max}, {mn, mx});
        check("launch_latency", 64'(miner_reset), 64'(mx >= mn));
        check("job_ready_low", 64'(job_ready), 64'(0));
    endtask

    // Waits out the launch pulse while throwing ignored pulses at the core.
    task automatic wait_start();
        int cnt = 0;
        while (miner_reset && cnt < 50) begin
            new_golden_nonce = 1'($urandom % 2);
            abort = 1'($urandom % 2);
            golden_nonce = $urandom;
            @(posedge hash_clk);
            #1;
            cnt++;
        end
        new_golden_nonce = 1'b0;
        abort = 1'b0;
        check("start_cycles", 64'(cnt), 64'(2));
    endtask

    // kind: 0 exhausted, 1 golden, 2 abort, 3 golden+abort together.
    task automatic run_job(input logic [7:0] id, input logic [31:0] mn,
                           input logic [31:0] mx, input int kind,
                           input int dly, input int stall_at);
        longint budget;
        logic [31:0] gn;
        int n;
        bit seen;
        send_job(id, mn, mx);
        if (mx < mn) begin
            push_frame(id, 8'h03, 32'h0);
            n = 0;
            seen = 0;
            while (busy && n < 20000) begin
                if (miner_reset) seen = 1;
                @(posedge hash_clk);
                #1;
                n++;
            end
            check("reject_no_start", 64'(seen), 64'(0));
            return;
        end
        wait_start();
        budget = (longint'(mx) - longint'(mn) + 1) * 32 + 160;
        if (kind == 0) begin
            push_frame(id, 8'h00, mx);
            n = 0;
            while (!tx_valid && n < budget + 100) begin
                @(posedge hash_clk);
                #1;
                n++;
            end
            check("run_cycles", 64'(n), 64'(budget));
        end else begin
            repeat (dly) begin
                @(posedge hash_clk);
                #1;
            end
            gn = $urandom;
            push_frame(id, (kind == 2) ? 8'h02 : 8'h01,
                       (kind == 2) ? 32'h0 : gn);
            new_golden_nonce = kind != 2;
            abort = kind >= 2;
            golden_nonce = gn;
            @(posedge hash_clk);
            #1;
            new_golden_nonce = 1'b0;
            abort = 1'b0;
            golden_nonce = $urandom;
            check("result_latency", 64'(tx_valid), 64'(1));
            if (stall_at >= 0) begin
                n = 0;
                while (mon_idx != stall_at && n < 1000) begin
                    @(posedge hash_clk);
                    #1;
                    n++;
                end
                stall_cnt = 50;
            end
        end
        wait_idle();
    endtask

    task automatic do_reset(input string nm);
        reset_n = 1'b0;
        #1;
        check_zero(nm);
        exp_q.delete();
        new_golden_nonce = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge hash_clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int kind;
        int n;
        logic [31:0] mn;
        logic [31:0] gn;
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("reset_state");
        repeat (3) @(posedge hash_clk);
        #1;
        check_zero("reset_hold");
        reset_n = 1'b1;
        @(posedge hash_clk);
        #1;
        check("ready_after_reset", 64'({job_ready, busy}), 64'(2'b10));

        // Directed: golden nonce 0x157, then exhaustion of the same range.
        send_job(8'h42, 32'h100, 32'h1FF);
        wait_start();
        repeat (10) @(posedge hash_clk);
        #1;
        push_frame(8'h42, 8'h01, 32'h157);
        new_golden_nonce = 1'b1;
        golden_nonce = 32'h157;
        @(posedge hash_clk);
        #1;
        new_golden_nonce = 1'b0;
        check("found_latency", 64'(tx_valid), 64'(1));
        wait_idle();
        run_job(8'h42, 32'h100, 32'h1FF, 0, 0, -1);
        run_job(8'h17, 32'h10, 32'h0F, 0, 0, -1);
        run_job(8'h23, 32'h5, 32'h8, 3, 7, -1);
        run_job(8'h24, 32'h5, 32'h8, 2, 3, -1);
        run_job(8'h25, 32'h0, 32'h0, 0, 0, -1);

        // Random jobs under random back-pressure, one with a long stall.
        rand_rdy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 4);
            mn = $urandom;
            if (kind == 4)
                run_job(8'($urandom), mn, mn - 32'($urandom_range(1, 99)),
                        0, 0, -1);
            else
                run_job(8'($urandom), mn & 32'hFFFF_FFF0,
                        (mn & 32'hFFFF_FFF0) + 32'($urandom_range(0, 3)),
                        kind, $urandom_range(0, 40), (i == 5) ? 2 : -1);
        end
        run_job(8'h5A, 32'h0, 32'h0, 1, 4, 3);

        // Reset during RUN, then a clean job.
        send_job(8'h66, 32'h20, 32'h30);
        wait_start();
        repeat (20) @(posedge hash_clk);
        #1;
        do_reset("reset_in_run");
        run_job(8'h67, 32'h40, 32'h41, 1, 5, -1);

        // Reset while byte 3 of the frame is on the bus, then a clean job.
        send_job(8'h68, 32'h1, 32'h2);
        wait_start();
        gn = $urandom;
        push_frame(8'h68, 8'h01, gn);
        new_golden_nonce = 1'b1;
        golden_nonce = gn;
        @(posedge hash_clk);
        #1;
        new_golden_nonce = 1'b0;
        n = 0;
        while (mon_idx != 3 && n < 1000) begin
            @(posedge hash_clk);
            #1;
            n++;
        end
        check("reach_byte3", 64'(n >= 1000), 64'(0));
        do_reset("reset_in_report");
        rand_rdy = 1'b0;
        run_job(8'h69, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 9, -1);
        run_job(8'h6A, 32'h7, 32'h7, 2, 0, -1);

        repeat (5) @(posedge hash_clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
